// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: MMIO addresses,
// default baud divisor and the TX state encoding.
package mmio_uart_tx_pkg;

  localparam logic [31:0] ADDR_HALT = 32'hF000_0000;
  localparam logic [31:0] ADDR_UART = 32'hF000_0100;

  localparam int BAUD_DIV_DEFAULT   = 868;
  localparam int FIFO_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Status word returned by a read of the UART address.
  function automatic logic [31:0] uart_status(input logic overflow, input logic not_full);
    return {30'b0, overflow, not_full};
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a show-ahead head word; push is refused when full and
// pop when empty, both judged on the registered count.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale words are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, status register with
// sticky overflow, and a sticky halt flag for the CPU.
module mmio_uart_tx #(
  parameter int BAUD_DIV   = mmio_uart_tx_pkg::BAUD_DIV_DEFAULT,
  parameter int FIFO_DEPTH = mmio_uart_tx_pkg::FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_oe,
  input  logic [3:0]  mmio_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mmio_rdata,
  output logic        uart_txd,
  output logic        halt
);

  import mmio_uart_tx_pkg::*;

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  // MMIO decode
  logic wr_acc, rd_acc, hit_uart, hit_halt, uart_push, uart_read;

  assign wr_acc    = mmio_oe & mmio_we[0];
  assign rd_acc    = mmio_oe & ~mmio_we[0];
  assign hit_uart  = (mem_addr == ADDR_UART);
  assign hit_halt  = (mem_addr == ADDR_HALT);
  assign uart_push = wr_acc & hit_uart;
  assign uart_read = rd_acc & hit_uart;

  // FIFO
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [AW:0]   fifo_count;

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (uart_push),
    .wdata_i (mem_wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  logic unused_bits;
  assign unused_bits = ^{mmio_we[3:1], mem_wdata[31:8], fifo_count};

  // Status, overflow and halt registers
  logic        overflow_q, overflow_d;
  logic        halt_q, halt_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    overflow_d = overflow_q;
    if (uart_push && fifo_full) overflow_d = 1'b1;
    else if (uart_read)         overflow_d = 1'b0;
    halt_d  = halt_q | (wr_acc & hit_halt);
    rdata_d = uart_read ? uart_status(overflow_q, ~fifo_full) : 32'b0;
  end

  // TX state machine and baud counter
  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = TX_START;
          txd_d    = 1'b0;
        end
      end
      TX_START: begin
        baud_d = bit_end ? '0 : baud_q + CW'(1);
        if (bit_end) begin
          state_d   = TX_DATA;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
        end
      end
      TX_DATA: begin
        baud_d = bit_end ? '0 : baud_q + CW'(1);
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = TX_STOP;
            txd_d   = 1'b1;
          end else begin
            // Line is registered, so present the next bit while shifting.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
      TX_STOP: begin
        baud_d = bit_end ? '0 : baud_q + CW'(1);
        txd_d  = 1'b1;
        if (bit_end) state_d = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
        baud_d  = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
      rdata_q    <= 32'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
      halt_q     <= halt_d;
      rdata_q    <= rdata_d;
    end
  end

  assign uart_txd   = txd_q;
  assign halt       = halt_q;
  assign mmio_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a line monitor decodes frames against a
// scoreboard of expected bytes while the main sequence exercises MMIO.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam int BD    = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BD;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_oe;
  logic [3:0]  mmio_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mmio_rdata;
  logic        uart_txd;
  logic        halt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int frames      = 0;
  int low_cycles  = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  logic       mon_busy = 1'b0;
  int         mon_n    = 0;
  logic       mon_s [FRAME];

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mmio_oe    (mmio_oe),
    .mmio_we    (mmio_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mmio_rdata (mmio_rdata),
    .uart_txd   (uart_txd),
    .halt       (halt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic decode_frame();
    logic [7:0] b;
    int         unstable;
    unstable = 0;
    for (int i = 0; i < 8; i++) b[i] = mon_s[(i + 1) * BD + BD / 2];
    for (int j = 0; j < 10; j++)
      for (int k = 0; k < BD; k++)
        if (mon_s[j * BD + k] !== mon_s[j * BD + BD / 2]) unstable++;
    check("frame_start_bit", {31'b0, mon_s[BD / 2]}, 32'd0);
    check("frame_stop_bit", {31'b0, mon_s[9 * BD + BD / 2]}, 32'd1);
    check("frame_bit_width", unstable, 32'd0);
    check("frame_expected", {31'b0, exp_q.size() > 0}, 32'd1);
    if (exp_q.size() > 0) check("frame_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
    frames++;
  endtask

  // Line monitor: one sample per cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (uart_txd !== 1'b1) low_cycles++;
    if (rst) begin
      mon_busy = 1'b0;
    end else begin
      if (!mon_busy && uart_txd === 1'b0) begin
        mon_busy = 1'b1;
        mon_n    = 0;
        start_q.push_back(cyc);
      end
      if (mon_busy) begin
        mon_s[mon_n] = uart_txd;
        mon_n++;
        if (mon_n == FRAME) begin
          mon_busy = 1'b0;
          decode_frame();
        end
      end
    end
  end

  task automatic mmio_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    mmio_oe   = 1'b1;
    mmio_we   = we;
    mem_addr  = a;
    mem_wdata = d;
    @(posedge clk); #1;
    mmio_oe = 1'b0;
    mmio_we = 4'b0;
  endtask

  task automatic mmio_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    mmio_oe  = 1'b1;
    mmio_we  = 4'b0;
    mem_addr = a;
    @(posedge clk); #1;
    mmio_oe = 1'b0;
    check(tag, mmio_rdata, exp);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && frames < target; i++) @(posedge clk);
    #1;
    check(tag, frames, target);
  endtask

  initial begin
    int f0, lc0, s0;
    rst = 1'b1; mmio_oe = 1'b0; mmio_we = 4'b0; mem_addr = 32'b0; mem_wdata = 32'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", uart_txd, 32'd1);
    check("reset_halt", halt, 32'd0);
    check("reset_rdata", mmio_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single byte: start bit two cycles after the write.
    exp_q.push_back(8'h55);
    mmio_write(ADDR_UART, 32'h0000_0055, 4'hF);
    check("t55_pre_start", uart_txd, 32'd1);
    @(posedge clk); #1;
    check("t55_start_low", uart_txd, 32'd0);
    wait_frames("t55_frame_done", 1, FRAME + 10);
    repeat (2) @(posedge clk); #1;
    check("t55_idle_high", uart_txd, 32'd1);

    // Status read on an empty FIFO, then the read port returns to zero.
    mmio_read("empty_status", ADDR_UART, 32'h1);
    @(posedge clk); #1;
    check("rdata_zero_after", mmio_rdata, 32'd0);

    // Burst of six: one popped at once, four buffered, sixth dropped.
    f0 = frames;
    s0 = start_q.size();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'h41 + 8'(i));
      mmio_write(ADDR_UART, 32'h41 + i, 4'hF);
    end
    mmio_read("burst_overflow", ADDR_UART, 32'h2);
    mmio_read("burst_ovf_clear", ADDR_UART, 32'h0);
    wait_frames("burst_frames", f0 + 5, 6 * (FRAME + 1) + 20);
    for (int k = 1; k < 5; k++)
      check("burst_period", start_q[s0 + k] - start_q[s0 + k - 1], FRAME + 1);
    check("burst_sb_drained", exp_q.size(), 32'd0);
    mmio_read("burst_status_after", ADDR_UART, 32'h1);

    // Halt is set the cycle after the write and is sticky.
    check("halt_before", halt, 32'd0);
    mmio_write(ADDR_HALT, 32'h0, 4'hF);
    check("halt_set", halt, 32'd1);

    // Accesses that must not touch the FIFO.
    f0  = frames;
    lc0 = low_cycles;
    mmio_write(ADDR_UART, 32'h77, 4'b1110);
    mmio_write(32'hF000_0104, 32'h77, 4'hF);
    mmio_oe = 1'b0; mmio_we = 4'hF; mem_addr = ADDR_UART; mem_wdata = 32'h77;
    @(posedge clk); #1;
    mmio_we = 4'b0;
    mmio_read("other_addr_read", 32'hF000_0104, 32'h0);
    repeat (FRAME) @(posedge clk);
    #1;
    check("ignore_no_frame", frames, f0);
    check("ignore_line_high", low_cycles, lc0);
    mmio_read("ignore_status", ADDR_UART, 32'h1);
    check("halt_sticky", halt, 32'd1);

    // Reset in the middle of a frame with two bytes queued.
    mmio_write(ADDR_UART, 32'hA1, 4'hF);
    mmio_write(ADDR_UART, 32'hA2, 4'hF);
    mmio_write(ADDR_UART, 32'hA3, 4'hF);
    repeat (4 * BD + 1) @(posedge clk);
    #1;
    check("mid_frame_low_seen", {31'b0, mon_busy}, 32'd1);
    f0  = frames;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_txd_high", uart_txd, 32'd1);
    check("rst_halt_clear", halt, 32'd0);
    check("rst_rdata_zero", mmio_rdata, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    lc0 = low_cycles;
    repeat (3 * FRAME) @(posedge clk);
    #1;
    check("rst_no_frames", frames, f0);
    check("rst_line_high", low_cycles, lc0);
    mmio_read("rst_status", ADDR_UART, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter: BAUD_DIV, default 868, clock cycles per UART bit (100 MHz / 115200).
REQ-002 Parameter: FIFO_DEPTH, default 16, TX byte buffer entries; power of two, at least 2.
REQ-003 Port: clk  input  1  system clock; the single clock domain.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: mmio_oe  input  1  MMIO access strobe from the CPU, one cycle per access.
REQ-006 Port: mmio_we  input  4  byte write enables; mmio_we[0]=1 marks a write, 0 marks a read.
REQ-007 Port: mem_addr  input  32  access address.
REQ-008 Port: mem_wdata  input  32  write data; bits [7:0] carry the TX byte.
REQ-009 Port: mmio_rdata  output  32  read data, registered.
REQ-010 Port: uart_txd  output  1  serial line, 8N1, idle high.
REQ-011 Port: halt  output  1  sticky halt flag.

Function
REQ-012 Address 0xF000_0100 with mmio_oe=1 and mmio_we[0]=1 shall push mem_wdata[7:0] into the FIFO when count < FIFO_DEPTH.
REQ-013 A push while count == FIFO_DEPTH shall drop the byte and set sticky overflow; a pop in the same cycle does not rescue it, because fullness is judged on the registered count.
REQ-014 A read of 0xF000_0100 (mmio_oe=1, mmio_we[0]=0) shall return {30'b0, overflow, ~full} on mmio_rdata in the cycle after the access; that read shall clear overflow.
REQ-015 When no read was accepted in the previous cycle, mmio_rdata shall be 0; reads of any other address shall return 0.
REQ-016 Address 0xF000_0000 with mmio_oe=1 and mmio_we[0]=1 shall set halt the following cycle; halt stays set until rst.
REQ-017 Accesses to any other address, or with mmio_oe=0, shall have no effect.
REQ-018 TX FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE: if the FIFO is not empty, pop the head into the shift register and enter START; uart_txd drives 0 from the next cycle.
REQ-020 START: hold 0 for BAUD_DIV cycles, then enter DATA.
REQ-021 DATA: shift out 8 bits LSB first, each held BAUD_DIV cycles, using a 3-bit bit index, then enter STOP.
REQ-022 STOP: hold 1 for BAUD_DIV cycles, then enter IDLE.
REQ-023 A queued byte's start bit shall follow the stop bit with no idle gap beyond the one IDLE cycle.
REQ-024 Frame length: 10*BAUD_DIV cycles; back-to-back frame period: 10*BAUD_DIV+1 cycles.
REQ-025 The baud counter shall count 0..BAUD_DIV-1, wrap at the end of each bit, and be cleared on entering START.
REQ-026 FIFO pointers shall be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count shall be log2(FIFO_DEPTH)+1 bits.
REQ-027 A simultaneous push and pop on a non-full FIFO shall leave count unchanged.
REQ-028 A push to an empty FIFO while in IDLE shall start the frame in the following cycle: the pop occurs the cycle after the push, and start bit 0 appears one cycle later.

Reset
REQ-029 On rst: uart_txd=1, halt=0, overflow=0, mmio_rdata=0, FSM=IDLE, baud counter=0, FIFO empty.
REQ-030 rst asserted mid-frame shall abort the frame: uart_txd is 1 in the cycle after the reset edge and buffered bytes are discarded.

Structure
REQ-031 A shared package shall hold the MMIO addresses (HALT 0xF000_0000, UART 0xF000_0100), the BAUD_DIV default and the TX state encoding.
REQ-032 The FIFO shall be a sub-module, fifo_sync (parameters WIDTH, DEPTH; push/pop/full/empty/count).
REQ-033 The FSM and baud counter shall live in mmio_uart_tx.

Verification (BAUD_DIV=4, FIFO_DEPTH=4)
REQ-034 Write 0x55 to 0xF000_0100 -> uart_txd = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, start bit 2 cycles after the write; then idle high.
REQ-035 Six back-to-back writes 0x41..0x46 -> first five transmitted (one popped immediately plus four buffered), sixth dropped; the following read returns 0x2 (or 0x3 once space frees) and the next read shows overflow=0.
REQ-036 Read 0xF000_0100 with the FIFO empty -> mmio_rdata=0x1 one cycle later, 0 the cycle after that.
REQ-037 Write 0xF000_0000 -> halt=1 next cycle; stays 1 through later traffic until rst.
REQ-038 Assert rst at bit 3 of a frame with 2 bytes queued -> uart_txd=1 next cycle, no further frames, status read returns 0x1.
REQ-039 Writes with mmio_we=4'b1110 or to 0xF000_0104 -> no FIFO change, uart_txd stays 1.
